// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
// Holds the FSM state encoding, a clog2 helper and default timeout constants.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    BUSY    = 3'd2,
    RELEASE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int DEF_N_MASTERS   = 4;
  localparam int DEF_ID_WIDTH    = 2;
  localparam int DEF_ACK_TIMEOUT = 16;
  localparam int DEF_HOLD_LIMIT  = 1024;
  localparam int DEF_CNT_WIDTH   = 11;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the eligible vector so the bit after
// the pointer sits at position 0, take the lowest set bit, then rotate back.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ID_WIDTH  = DEF_ID_WIDTH
) (
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [ID_WIDTH-1:0]  ptr,
  output logic                 found,
  output logic [ID_WIDTH-1:0]  winner,
  output logic [N_MASTERS-1:0] onehot
);

  localparam int unsigned NM = N_MASTERS;

  logic [2*N_MASTERS-1:0] doubled;
  logic [2*N_MASTERS-1:0] shifted;
  logic [N_MASTERS-1:0]   rotated;
  int unsigned            shamt;
  int unsigned            pos;
  int unsigned            sum;

  always_comb begin
    doubled = {eligible, eligible};
    shamt   = 32'(ptr) + 32'd1;
    shifted = doubled >> shamt;
    rotated = shifted[N_MASTERS-1:0];

    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (rotated[i] && !found) begin
        found = 1'b1;
        pos   = i;
      end
    end

    // pos + shamt never exceeds 2*N-1, so one conditional subtract wraps it
    sum = pos + shamt;
    if (sum >= NM) begin
      sum = sum - NM;
    end
    winner = sum[ID_WIDTH-1:0];

    onehot = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      onehot[i] = found && (i == sum);
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin arbiter with enable mask and grant-acknowledge timeout.
// Define BUS_WATCHDOG_EN to build the hold watchdog and DRAIN state.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS   = DEF_N_MASTERS,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int HOLD_LIMIT  = DEF_HOLD_LIMIT,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] mask,
  input  logic                 bus_util,
  output logic [N_MASTERS-1:0] grant,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic                 bus_idle,
  output logic                 ack_timeout,
  output logic                 wdog_timeout
);

  localparam logic [ID_WIDTH-1:0]  PTR_RST  = ID_WIDTH'(N_MASTERS - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state;
  logic [ID_WIDTH-1:0]    ptr;
  logic [CNT_WIDTH-1:0]   timer;
  logic [N_MASTERS-1:0]   eligible;
  logic                   found;
  logic [ID_WIDTH-1:0]    win_id;
  logic [N_MASTERS-1:0]   win_onehot;
  logic                   win_req;

  assign eligible = req & mask;
  // grant is one-hot while in GRANT, so this is the winner's own request
  assign win_req  = |(req & grant);
  assign bus_idle = (state == IDLE) && !bus_util;

  rr_picker #(
    .N_MASTERS (N_MASTERS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (found),
    .winner   (win_id),
    .onehot   (win_onehot)
  );

`ifdef BUS_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_LIMIT - 1);
  logic wdog_q;
  assign wdog_timeout = wdog_q;
`else
  assign wdog_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      ptr         <= PTR_RST;
      timer       <= '0;
      ack_timeout <= 1'b0;
`ifdef BUS_WATCHDOG_EN
      wdog_q      <= 1'b0;
`endif
    end else begin
      ack_timeout <= 1'b0;
`ifdef BUS_WATCHDOG_EN
      wdog_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found && !bus_util) begin
            grant    <= win_onehot;
            grant_id <= win_id;
            timer    <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (bus_util) begin
            ptr   <= grant_id;
            timer <= '0;
            state <= BUSY;
          end else if (!win_req) begin
            grant <= '0;
            state <= RELEASE;
          end else if (timer == ACK_LAST) begin
            ack_timeout <= 1'b1;
            grant       <= '0;
            ptr         <= grant_id;
            state       <= RELEASE;
          end else begin
            timer <= timer + CNT_ONE;
          end
        end
        BUSY: begin
          if (!bus_util) begin
            grant <= '0;
            state <= RELEASE;
          end
`ifdef BUS_WATCHDOG_EN
          else if (timer == HOLD_LAST) begin
            wdog_q <= 1'b1;
            grant  <= '0;
            state  <= DRAIN;
          end else begin
            timer <= timer + CNT_ONE;
          end
`endif
        end
        RELEASE: begin
          state <= IDLE;
        end
`ifdef BUS_WATCHDOG_EN
        DRAIN: begin
          if (!bus_util) begin
            state <= RELEASE;
          end
        end
`endif
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed table, corner sequences and
// randomized tenures checked against a transaction-level round-robin model.
module tb_bus_arbiter_rr;

  localparam int NM  = 4;
  localparam int IDW = bus_arb_pkg::clog2(NM);
  localparam int ACK = 16;
`ifdef BUS_WATCHDOG_EN
  localparam int HOLD = 32;
`else
  localparam int HOLD = 1024;
`endif

  localparam int K_NORMAL  = 0;
  localparam int K_ABANDON = 1;
  localparam int K_TIMEOUT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NM-1:0]  req;
  logic [NM-1:0]  mask;
  logic           bus_util;
  logic [NM-1:0]  grant;
  logic [IDW-1:0] grant_id;
  logic           bus_idle;
  logic           ack_timeout;
  logic           wdog_timeout;

  int checks = 0;
  int errors = 0;
  int mptr;
  int zeros = 2;

  bus_arbiter_rr #(
    .N_MASTERS   (NM),
    .ID_WIDTH    (IDW),
    .ACK_TIMEOUT (ACK),
    .HOLD_LIMIT  (HOLD),
    .CNT_WIDTH   (11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .mask         (mask),
    .bus_util     (bus_util),
    .grant        (grant),
    .grant_id     (grant_id),
    .bus_idle     (bus_idle),
    .ack_timeout  (ack_timeout),
    .wdog_timeout (wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first eligible index strictly after the last winner.
  function automatic int pick(input logic [NM-1:0] e);
    for (int k = 1; k <= NM; k++) begin
      int idx;
      idx = (mptr + k) % NM;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  // Continuous invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("grant_onehot0", int'($onehot0(grant)), 1);
`ifndef BUS_WATCHDOG_EN
      check("wdog_tied_low", int'(wdog_timeout), 0);
`endif
      if (grant != '0 && zeros > 0) check("turnaround_gap", int'(zeros >= 2), 1);
    end
    zeros = (grant == '0) ? zeros + 1 : 0;
  end

  task automatic wait_idle();
    for (int i = 0; i < 8 && !bus_idle; i++) tick();
    check("wait_idle", int'(bus_idle), 1);
  endtask

  task automatic run_tenure(input logic [NM-1:0] r, input logic [NM-1:0] m,
                            input logic [NM-1:0] mb, input int kind,
                            input int dly, input int len, input int exp);
    wait_idle();
    req      = r;
    mask     = m;
    bus_util = 1'b0;
    tick();
    if (exp < 0) begin
      for (int i = 0; i < 3; i++) begin
        check("no_grant", int'(grant), 0);
        check("no_grant_idle", int'(bus_idle), 1);
        tick();
      end
      return;
    end
    check("grant_onehot", int'(grant), 1 << exp);
    check("grant_id", int'(grant_id), exp);
    case (kind)
      K_NORMAL: begin
        for (int i = 0; i < dly; i++) begin
          tick();
          check("ack_wait_hold", int'(grant), 1 << exp);
        end
        bus_util = 1'b1;
        if (dly % 2 == 1) req[exp] = 1'b0;
        tick();
        check("busy_entry", int'(grant), 1 << exp);
        mask = mb;
        for (int i = 0; i < len; i++) begin
          tick();
          check("busy_hold", int'(grant), 1 << exp);
        end
        bus_util = 1'b0;
        tick();
        check("release_grant", int'(grant), 0);
        check("release_no_ack", int'(ack_timeout), 0);
        mptr = exp;
      end
      K_ABANDON: begin
        for (int i = 0; i < dly; i++) begin
          tick();
          check("abandon_hold", int'(grant), 1 << exp);
        end
        req[exp] = 1'b0;
        tick();
        check("abandon_grant", int'(grant), 0);
        check("abandon_no_ack", int'(ack_timeout), 0);
      end
      default: begin
        for (int i = 1; i < ACK; i++) begin
          tick();
          check("timeout_hold", int'(grant), 1 << exp);
          check("timeout_early", int'(ack_timeout), 0);
        end
        tick();
        check("timeout_pulse", int'(ack_timeout), 1);
        check("timeout_grant", int'(grant), 0);
        tick();
        check("timeout_pulse_end", int'(ack_timeout), 0);
        mptr = exp;
      end
    endcase
  endtask

  typedef struct {
    logic [NM-1:0] req;
    logic [NM-1:0] mask;
    logic [NM-1:0] mask_busy;
    int            kind;
    int            dly;
    int            len;
    int            exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vecs[0]  = '{4'b1111, 4'b1111, 4'b1111, K_NORMAL,  0, 5, 0};
    vecs[1]  = '{4'b1111, 4'b1111, 4'b1111, K_NORMAL,  0, 5, 1};
    vecs[2]  = '{4'b1111, 4'b1111, 4'b1111, K_NORMAL,  0, 5, 2};
    vecs[3]  = '{4'b1111, 4'b1111, 4'b1111, K_NORMAL,  0, 5, 3};
    vecs[4]  = '{4'b1111, 4'b1111, 4'b1111, K_NORMAL,  0, 5, 0};
    vecs[5]  = '{4'b0110, 4'b1011, 4'b0000, K_NORMAL,  2, 4, 1};
    vecs[6]  = '{4'b0110, 4'b1011, 4'b1011, K_NORMAL,  1, 3, 1};
    vecs[7]  = '{4'b0101, 4'b1111, 4'b1111, K_TIMEOUT, 0, 0, 2};
    vecs[8]  = '{4'b0101, 4'b1111, 4'b1111, K_NORMAL,  3, 2, 0};
    vecs[9]  = '{4'b1000, 4'b1111, 4'b1111, K_ABANDON, 4, 0, 3};
    vecs[10] = '{4'b1010, 4'b1111, 4'b1111, K_NORMAL,  0, 1, 1};
    vecs[11] = '{4'b0000, 4'b1111, 4'b1111, K_NORMAL,  0, 1, -1};

    rst      = 1'b1;
    req      = '0;
    mask     = '0;
    bus_util = 1'b0;
    repeat (3) tick();
    check("rst_grant", int'(grant), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_ack", int'(ack_timeout), 0);
    check("rst_wdog", int'(wdog_timeout), 0);
    check("rst_bus_idle", int'(bus_idle), 1);
    rst  = 1'b0;
    mptr = NM - 1;

    foreach (vecs[i]) begin
      run_tenure(vecs[i].req, vecs[i].mask, vecs[i].mask_busy, vecs[i].kind,
                 vecs[i].dly, vecs[i].len, vecs[i].exp);
    end

    // Foreign driver holding the bus while IDLE blocks arbitration.
    wait_idle();
    bus_util = 1'b1;
    req      = 4'b0001;
    mask     = 4'b1111;
    #1;
    check("foreign_bus_idle", int'(bus_idle), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("foreign_no_grant", int'(grant), 0);
      check("foreign_not_idle", int'(bus_idle), 0);
    end
    bus_util = 1'b0;
    #1;
    check("foreign_released_idle", int'(bus_idle), 1);
    for (int i = 0; i < 3 && grant == '0; i++) tick();
    check("foreign_then_grant", int'(grant), 4'b0001);
    bus_util = 1'b1;
    tick();
    bus_util = 1'b0;
    tick();
    check("foreign_release", int'(grant), 0);
    mptr = 0;

    // Reset in the middle of master 3's tenure.
    run_tenure(4'b1000, 4'b1111, 4'b1111, K_ABANDON, 0, 0, 3);
    wait_idle();
    req  = 4'b1000;
    mask = 4'b1111;
    tick();
    check("pre_rst_grant", int'(grant), 4'b1000);
    bus_util = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_grant", int'(grant), 0);
    check("midrst_grant_id", int'(grant_id), 0);
    check("midrst_ack", int'(ack_timeout), 0);
    check("midrst_wdog", int'(wdog_timeout), 0);
    bus_util = 1'b0;
    tick();
    rst  = 1'b0;
    req  = 4'b1111;
    mptr = NM - 1;
    tick();
    check("post_rst_winner", int'(grant), 4'b0001);
    check("post_rst_id", int'(grant_id), 0);
    bus_util = 1'b1;
    tick();
    bus_util = 1'b0;
    tick();
    check("post_rst_release", int'(grant), 0);
    mptr = 0;

    for (int n = 0; n < 40; n++) begin
      logic [NM-1:0] r, m, mb;
      int sel, kind;
      r    = NM'($urandom_range(0, 15));
      m    = NM'($urandom_range(0, 15)) | NM'($urandom_range(0, 15));
      mb   = NM'($urandom_range(0, 15));
      sel  = $urandom_range(0, 9);
      kind = (sel < 6) ? K_NORMAL : (sel < 8) ? K_ABANDON : K_TIMEOUT;
      run_tenure(r, m, mb, kind, $urandom_range(0, 6), $urandom_range(1, 6), pick(r & m));
    end

`ifdef BUS_WATCHDOG_EN
    // Master never releases: watchdog fires, then DRAIN blocks regrant.
    wait_idle();
    req  = 4'b0001;
    mask = 4'b1111;
    tick();
    check("wd_grant", int'(grant), 4'b0001);
    bus_util = 1'b1;
    tick();
    for (int k = 1; k < HOLD; k++) begin
      tick();
      check("wd_hold", int'(grant), 4'b0001);
      check("wd_early", int'(wdog_timeout), 0);
    end
    tick();
    check("wd_pulse", int'(wdog_timeout), 1);
    check("wd_grant_drop", int'(grant), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wd_drain_no_grant", int'(grant), 0);
      check("wd_drain_not_idle", int'(bus_idle), 0);
      check("wd_pulse_once", int'(wdog_timeout), 0);
    end
    bus_util = 1'b0;
    tick();
    check("wd_release1", int'(grant), 0);
    tick();
    check("wd_release2", int'(grant), 0);
    tick();
    check("wd_regrant", int'(grant), 4'b0001);
    bus_util = 1'b1;
    tick();
    bus_util = 1'b0;
    tick();
    mptr = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
